// File: rtl/run_monitor.sv
// Run controller and statistics unit: starts a run, drives programmable
// interrupt windows, counts cycles/retires/predictions, and freezes the
// counts when the core completes or the cycle budget runs out.
module run_monitor #(
  parameter int unsigned NUM_INTR   = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_chan,
  input  logic [CNT_W-1:0]    cfg_start,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic                retire_valid,
  input  logic [1:0]          retire_kind,
  input  logic                pred_valid,
  input  logic                pred_hit,
  input  logic                completed,
  output logic [NUM_INTR-1:0] intr,
  output logic [CNT_W-1:0]    cycles,
  output logic [CNT_W-1:0]    instr_total,
  output logic [CNT_W-1:0]    instr_normal,
  output logic [CNT_W-1:0]    instr_exc,
  output logic [CNT_W-1:0]    instr_other,
  output logic [CNT_W-1:0]    pred_total,
  output logic [CNT_W-1:0]    pred_succ,
  output logic [CNT_W-1:0]    pred_fail,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

  // 64-bit compare keeps the budget exact for any legal CNT_W up to 64.
  localparam logic [63:0] LastCycle = 64'(MAX_CYCLES) - 64'd1;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] it_q, it_d, in_q, in_d, ie_q, ie_d, io_q, io_d;
  logic [CNT_W-1:0] pt_q, pt_d, ps_q, ps_d, pf_q, pf_d;
  logic [NUM_INTR-1:0] intr_q, intr_d;
  logic [CNT_W-1:0] win_start_q [NUM_INTR];
  logic [CNT_W-1:0] win_start_d [NUM_INTR];
  logic [CNT_W-1:0] win_len_q [NUM_INTR];
  logic [CNT_W-1:0] win_len_d [NUM_INTR];

  logic at_limit, cfg_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  // End of window computed one bit wider so start+len never wraps.
  function automatic logic in_window(input logic [CNT_W-1:0] cyc,
                                     input logic [CNT_W-1:0] st,
                                     input logic [CNT_W-1:0] len);
    logic [CNT_W:0] lim;
    lim = {1'b0, st} + {1'b0, len};
    return (len != '0) && (cyc >= st) && ({1'b0, cyc} < lim);
  endfunction

  assign at_limit = (64'(cycles_q) == LastCycle);
  assign cfg_ok   = cfg_we && (state_q != StRun);

  // Next-state logic; completion beats timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: if (start) state_d = StRun;
      StRun: begin
        if (completed)     state_d = StDone;
        else if (at_limit) state_d = StTimeout;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters: cleared on entering RUN, advance only in RUN, frozen otherwise.
  always_comb begin
    cycles_d = cycles_q;
    it_d = it_q; in_d = in_q; ie_d = ie_q; io_d = io_q;
    pt_d = pt_q; ps_d = ps_q; pf_d = pf_q;
    if (state_q != StRun && start) begin
      cycles_d = '0;
      it_d = '0; in_d = '0; ie_d = '0; io_d = '0;
      pt_d = '0; ps_d = '0; pf_d = '0;
    end else if (state_q == StRun) begin
      cycles_d = sat_inc(cycles_q);
      if (retire_valid) begin
        it_d = sat_inc(it_q);
        case (retire_kind)
          2'd0:    in_d = sat_inc(in_q);
          2'd1:    ie_d = sat_inc(ie_q);
          default: io_d = sat_inc(io_q);
        endcase
      end
      if (pred_valid) begin
        pt_d = sat_inc(pt_q);
        if (pred_hit) ps_d = sat_inc(ps_q);
        else          pf_d = sat_inc(pf_q);
      end
    end
  end

  // Window config writes (out-of-range channels match no slot) and the
  // registered interrupt lines, evaluated against the cycle count that will
  // be visible during the next cycle.
  always_comb begin
    for (int unsigned k = 0; k < NUM_INTR; k++) begin
      win_start_d[k] = win_start_q[k];
      win_len_d[k]   = win_len_q[k];
      if (cfg_ok && (32'(cfg_chan) == k)) begin
        win_start_d[k] = cfg_start;
        win_len_d[k]   = cfg_len;
      end
      intr_d[k] = (state_d == StRun) && in_window(cycles_d, win_start_d[k], win_len_d[k]);
    end
  end

  // State, counter, window and interrupt registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cycles_q <= '0;
      it_q <= '0; in_q <= '0; ie_q <= '0; io_q <= '0;
      pt_q <= '0; ps_q <= '0; pf_q <= '0;
      intr_q   <= '0;
      for (int unsigned k = 0; k < NUM_INTR; k++) begin
        win_start_q[k] <= '0;
        win_len_q[k]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      it_q <= it_d; in_q <= in_d; ie_q <= ie_d; io_q <= io_d;
      pt_q <= pt_d; ps_q <= ps_d; pf_q <= pf_d;
      intr_q   <= intr_d;
      for (int unsigned k = 0; k < NUM_INTR; k++) begin
        win_start_q[k] <= win_start_d[k];
        win_len_q[k]   <= win_len_d[k];
      end
    end
  end

  assign intr         = intr_q;
  assign cycles       = cycles_q;
  assign instr_total  = it_q;
  assign instr_normal = in_q;
  assign instr_exc    = ie_q;
  assign instr_other  = io_q;
  assign pred_total   = pt_q;
  assign pred_succ    = ps_q;
  assign pred_fail    = pf_q;
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign timeout      = (state_q == StTimeout);

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench: three run_monitor instances share stimulus.
//   a: default budget, b: MAX_CYCLES=20, c: CNT_W=4 (saturation).
module tb_run_monitor;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, cfg_we = 1'b0;
  logic [2:0]  cfg_chan = '0;
  logic [31:0] cfg_start = '0, cfg_len = '0;
  logic        retire_valid = 1'b0, pred_valid = 1'b0, pred_hit = 1'b0, completed = 1'b0;
  logic [1:0]  retire_kind = '0;

  logic [1:0]  a_intr, b_intr, c_intr;
  logic [31:0] a_cyc, a_it, a_in, a_ie, a_io, a_pt, a_ps, a_pf;
  logic [31:0] b_cyc, b_it, b_in, b_ie, b_io, b_pt, b_ps, b_pf;
  logic [3:0]  c_cyc, c_it, c_in, c_ie, c_io, c_pt, c_ps, c_pf;
  logic        a_busy, a_done, a_to, b_busy, b_done, b_to, c_busy, c_done, c_to;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_monitor #(.NUM_INTR(2), .CNT_W(32), .MAX_CYCLES(100000)) u_a (
    .clk(clk), .rstn(rstn), .start(start), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .retire_valid(retire_valid),
    .retire_kind(retire_kind), .pred_valid(pred_valid), .pred_hit(pred_hit),
    .completed(completed), .intr(a_intr), .cycles(a_cyc), .instr_total(a_it),
    .instr_normal(a_in), .instr_exc(a_ie), .instr_other(a_io), .pred_total(a_pt),
    .pred_succ(a_ps), .pred_fail(a_pf), .busy(a_busy), .done(a_done), .timeout(a_to)
  );

  run_monitor #(.NUM_INTR(2), .CNT_W(32), .MAX_CYCLES(20)) u_b (
    .clk(clk), .rstn(rstn), .start(start), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .retire_valid(retire_valid),
    .retire_kind(retire_kind), .pred_valid(pred_valid), .pred_hit(pred_hit),
    .completed(completed), .intr(b_intr), .cycles(b_cyc), .instr_total(b_it),
    .instr_normal(b_in), .instr_exc(b_ie), .instr_other(b_io), .pred_total(b_pt),
    .pred_succ(b_ps), .pred_fail(b_pf), .busy(b_busy), .done(b_done), .timeout(b_to)
  );

  run_monitor #(.NUM_INTR(2), .CNT_W(4), .MAX_CYCLES(1000)) u_c (
    .clk(clk), .rstn(rstn), .start(start), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_start(cfg_start[3:0]), .cfg_len(cfg_len[3:0]), .retire_valid(retire_valid),
    .retire_kind(retire_kind), .pred_valid(pred_valid), .pred_hit(pred_hit),
    .completed(completed), .intr(c_intr), .cycles(c_cyc), .instr_total(c_it),
    .instr_normal(c_in), .instr_exc(c_ie), .instr_other(c_io), .pred_total(c_pt),
    .pred_succ(c_ps), .pred_fail(c_pf), .busy(c_busy), .done(c_done), .timeout(c_to)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected lines for windows ch0 [10,13) and ch1 [12,14).
  function automatic logic [1:0] exp_intr(input int c);
    return {(c >= 12 && c < 14), (c >= 10 && c < 13)};
  endfunction

  initial begin
    // Reset state
    #1;
    check("rst busy", a_busy, 0);
    check("rst done", a_done, 0);
    check("rst timeout", a_to, 0);
    check("rst cycles", a_cyc, 0);
    check("rst intr", a_intr, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Phase 1: windows, basic completion, timeout on b, saturation on c
    cfg_we = 1'b1; cfg_chan = 3'd0; cfg_start = 10; cfg_len = 3;
    tick();
    cfg_chan = 3'd1; cfg_start = 12; cfg_len = 2; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("p1 busy", a_busy, 1);
    for (int k = 1; k <= 50; k++) begin
      check($sformatf("p1 intr c=%0d", k - 1), a_intr, exp_intr(k - 1));
      retire_valid = 1'b1; retire_kind = 2'd0; completed = (k == 50);
      tick();
    end
    retire_valid = 1'b0; completed = 1'b0;
    check("p1 done", a_done, 1);
    check("p1 busy end", a_busy, 0);
    check("p1 cycles", a_cyc, 50);
    check("p1 instr_total", a_it, 50);
    check("p1 instr_normal", a_in, 50);
    check("p1 instr_exc", a_ie, 0);
    check("p1 instr_other", a_io, 0);
    check("p1 pred_total", a_pt, 0);
    check("p1 intr end", a_intr, 0);
    check("p1 b timeout", b_to, 1);
    check("p1 b done", b_done, 0);
    check("p1 b cycles", b_cyc, 20);
    check("p1 b intr", b_intr, 0);
    check("p1 c instr_total sat", c_it, 15);
    check("p1 c cycles sat", c_cyc, 15);
    check("p1 c done", c_done, 1);
    tick();
    check("p1 a frozen", a_cyc, 50);

    // Phase 2: restart, gated config, retire/prediction mix, b completes at budget
    start = 1'b1;
    tick();
    start = 1'b0;
    check("p2 busy", a_busy, 1);
    check("p2 cycles clr", a_cyc, 0);
    check("p2 instr_total clr", a_it, 0);
    check("p2 b busy", b_busy, 1);
    check("p2 b cycles clr", b_cyc, 0);
    check("p2 c instr_total clr", c_it, 0);
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("p2 intr c=%0d", k - 1), a_intr, exp_intr(k - 1));
      cfg_we = (k == 1); cfg_chan = 3'd0; cfg_start = 2; cfg_len = 1;
      pred_valid = (k <= 10); pred_hit = (k <= 7);
      retire_valid = (k <= 6); retire_kind = (k <= 4) ? 2'd1 : 2'd3;
      completed = (k == 20);
      tick();
    end
    cfg_we = 1'b0; pred_valid = 1'b0; pred_hit = 1'b0;
    retire_valid = 1'b0; retire_kind = 2'd0; completed = 1'b0;
    check("p2 done", a_done, 1);
    check("p2 cycles", a_cyc, 20);
    check("p2 pred_total", a_pt, 10);
    check("p2 pred_succ", a_ps, 7);
    check("p2 pred_fail", a_pf, 3);
    check("p2 instr_exc", a_ie, 4);
    check("p2 instr_other", a_io, 2);
    check("p2 instr_total", a_it, 6);
    check("p2 instr_normal", a_in, 0);
    check("p2 b done", b_done, 1);
    check("p2 b timeout", b_to, 0);
    check("p2 b cycles", b_cyc, 20);

    // Phase 3: asynchronous reset mid-run, windows cleared afterwards
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      retire_valid = 1'b1;
      tick();
    end
    check("p3 intr pre-rst", a_intr, 2'b01);
    check("p3 cycles pre-rst", a_cyc, 11);
    #1 rstn = 1'b0;
    #1;
    check("p3 rst busy", a_busy, 0);
    check("p3 rst done", a_done, 0);
    check("p3 rst timeout", a_to, 0);
    check("p3 rst cycles", a_cyc, 0);
    check("p3 rst instr_total", a_it, 0);
    check("p3 rst intr", a_intr, 0);
    check("p3 rst c instr_total", c_it, 0);
    retire_valid = 1'b0;
    tick();
    rstn = 1'b1;
    // Out-of-range channel write must not land on any window
    cfg_we = 1'b1; cfg_chan = 3'd4; cfg_start = 0; cfg_len = 5;
    tick();
    cfg_we = 1'b0;
    check("p3 idle after rst", a_busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("p3 intr cleared c=%0d", k - 1), a_intr, 0);
      tick();
    end
    check("p3 cycles rerun", a_cyc, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller and statistics unit for core simulation and FPGA bring-up.
- Generates NUM_INTR programmable interrupt pulse windows toward the core.
- Counts run cycles, retired instructions by class, and branch-prediction outcomes.
- Stops on the core's `completed` flag or on a cycle-budget timeout, then freezes all counts for readout.

Parameters:
- NUM_INTR, 2, number of interrupt output channels (1..8); channel 0 = external, channel 1 = timer by convention.
- CNT_W, 32, width of every counter and of the window start/length fields.
- MAX_CYCLES, 100000, run-cycle budget before timeout (1 .. 2^CNT_W-1).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a run
- cfg_we  in  1  window config write strobe
- cfg_chan  in  3  channel index for the write
- cfg_start  in  CNT_W  first run cycle the channel is asserted
- cfg_len  in  CNT_W  number of cycles asserted; 0 = channel disabled
- retire_valid  in  1  one instruction retired this cycle
- retire_kind  in  2  retired class: 0 normal, 1 exception, 2/3 other
- pred_valid  in  1  branch resolved this cycle
- pred_hit  in  1  prediction was correct (valid only with pred_valid)
- completed  in  1  core finished its program
- intr  out  NUM_INTR  interrupt lines to core
- cycles  out  CNT_W  run cycle count
- instr_total, instr_normal, instr_exc, instr_other  out  CNT_W each  retire counters
- pred_total, pred_succ, pred_fail  out  CNT_W each  prediction counters
- busy  out  1  state == RUN
- done  out  1  state == DONE
- timeout  out  1  state == TIMEOUT

Behaviour:
- Reset (asynchronous, rstn low):
  - State goes to IDLE.
  - All counters and intr clear to 0; busy/done/timeout clear to 0.
  - Every channel window clears to start=0, len=0.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE --start--> RUN.
  - RUN --completed--> DONE.
  - RUN --(cycles == MAX_CYCLES-1 and !completed)--> TIMEOUT.
  - DONE/TIMEOUT --start--> RUN.
  - Every transition takes effect on the next clock edge.
- Counter clear: entering RUN clears all counters in the same edge. Window config is preserved.
- Config writes:
  - Accepted only in IDLE, DONE or TIMEOUT; ignored in RUN.
  - cfg_chan >= NUM_INTR is ignored.
  - A write in the same cycle as start is accepted and applies to the new run.
- RUN cycle counting:
  - cycles increments by 1 every RUN cycle, including the cycle in which completed is sampled.
  - A run that completes on its k-th RUN cycle reports cycles = k.
- Retire and prediction counting (RUN cycles only, including the completing cycle):
  - retire_valid increments instr_total and the counter selected by retire_kind.
  - pred_valid increments pred_total and either pred_succ or pred_fail, per pred_hit.
  - Inputs are ignored outside RUN.
- Saturation: every counter saturates at all-ones and never wraps.
- Interrupt windows:
  - intr[k] is registered. It is high in a RUN cycle iff len_k != 0 and start_k <= cycles < start_k + len_k, with the sum computed in CNT_W+1 bits (no wrap).
  - Comparison uses the cycles value present at the start of that cycle. Because the output is a register, it is the value before the increment.
  - intr is all-zero outside RUN and drops in the same edge that leaves RUN.
  - Windows on different channels are independent and may overlap.
- Freeze: in DONE/TIMEOUT all counters hold until the next start or reset.
- Simultaneous events:
  - completed and the timeout condition in the same cycle: DONE wins.
  - start while in RUN is ignored.
  - completed outside RUN is ignored.
- Reset mid-run: aborts immediately to IDLE with all outputs 0 and windows cleared.

Test Plan:
- Basic completion: reset, start at cycle 0, retire_valid every cycle (kind 0), completed on the 50th RUN cycle.
  - Required: done=1, cycles=50, instr_total=instr_normal=50, other counters 0.
- Two interrupt windows: ch0 start=10 len=3, ch1 start=12 len=2.
  - Required: intr[0] high for cycles 10..12, intr[1] high for cycles 12..13, both high at cycle 12, 0 elsewhere.
- Timeout: MAX_CYCLES=20, completed held low.
  - Required: timeout=1, cycles=20, intr=0 afterwards.
  - Also: completed asserted on cycle 20 → done=1, not timeout.
- Prediction and retire mix: 7 hits, 3 misses, 4 exceptions, 2 kind-3 retires.
  - Required: pred_total=10, pred_succ=7, pred_fail=3, instr_exc=4, instr_other=2, instr_total=6.
- Config gating and restart:
  - cfg_we during RUN is ignored (window unchanged).
  - start from DONE clears all counters to 0 and the prior window is reused.
- Saturation and reset: CNT_W=4, 20 retires → instr_total=15. rstn low mid-run → all outputs 0 asynchronously, state IDLE.
